// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path.
//   rx_state_t      : receiver FSM state encoding
//   OVERSAMPLE      : s_tick pulses per bit period
//   START_MID       : tick index at the middle of the start bit
//   DEFAULT_DBIT    : default data bits per frame
//   DEFAULT_SB_TICK : default tick count of the stop period
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int OVERSAMPLE      = 16;
    localparam int START_MID       = 7;
    localparam int DEFAULT_DBIT    = 8;
    localparam int DEFAULT_SB_TICK = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

endpackage

// File: rtl/uart_rx_deser_sync.sv
// ---------------------------------------------------------------------------
// rx_sync
// Two-flop synchronizer for the asynchronous serial line. Both flops reset
// to 1 so an idle line is seen during and right after reset.
//   clk   : clock
//   reset : synchronous, active-low
//   rx    : asynchronous serial input
//   rx_s  : synchronized copy of rx, 2 clk later
// ---------------------------------------------------------------------------
module rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic rx,
    output logic rx_s
);

    logic meta;

    // Two back-to-back flops; the first may go metastable, the second gives
    // it a full clock to settle before anything downstream looks at it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            meta <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            meta <= rx;
            rx_s <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_deser.sv
// ---------------------------------------------------------------------------
// uart_rx_deser
// UART receive deserializer: 16x oversampling, start/stop validation and
// LSB-first word assembly. Feeds the receive FIFO directly.
// Optional parity checking is compiled in with the macro UART_RX_PARITY_EN.
//   clk          : clock
//   reset        : synchronous, active-low
//   rx           : asynchronous serial line, idle high
//   s_tick       : one-clk enable at 16x baud
//   dout         : last completed word
//   rx_done_tick : one-cycle pulse per completed frame (FIFO wr)
//   frame_err    : stop bit was low for the last completed frame
//   parity_err   : parity mismatch for the last completed frame
// ---------------------------------------------------------------------------
module uart_rx_deser
    import uart_pkg::*;
#(
    parameter int DBIT       = DEFAULT_DBIT,
    parameter int SB_TICK    = DEFAULT_SB_TICK,
    parameter int PARITY_ODD = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    input  logic            s_tick,
    output logic [DBIT-1:0] dout,
    output logic            rx_done_tick,
    output logic            frame_err,
    output logic            parity_err
);

    // The tick counter must reach SB_TICK-1 in the stop state, so it grows
    // beyond 4 bits for 1.5 or 2 stop bits.
    localparam int S_W = (SB_TICK > OVERSAMPLE) ? $clog2(SB_TICK) : 4;
    localparam int N_W = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [S_W-1:0] S_MID  = S_W'(START_MID);
    localparam logic [S_W-1:0] S_LAST = S_W'(OVERSAMPLE - 1);
    localparam logic [S_W-1:0] S_STOP = S_W'(SB_TICK - 1);
    localparam logic [N_W-1:0] N_LAST = N_W'(DBIT - 1);

    logic            rx_s;
    rx_state_t       state;
    logic [S_W-1:0]  s;
    logic [N_W-1:0]  n;
    logic [DBIT-1:0] b;

    rx_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .rx    (rx),
        .rx_s  (rx_s)
    );

`ifdef UART_RX_PARITY_EN
    logic par_pend;
    logic par_err_reg;
    assign parity_err = par_err_reg;
`else
    assign parity_err = 1'b0;
`endif

    // Receiver FSM. Leaving IDLE is immediate on a low line; every other
    // state only moves on s_tick. Completion outputs are registered here so
    // rx_done_tick appears the cycle after the final stop tick.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            s            <= '0;
            n            <= '0;
            b            <= '0;
            dout         <= '0;
            rx_done_tick <= 1'b0;
            frame_err    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_pend     <= 1'b0;
            par_err_reg  <= 1'b0;
`endif
        end else begin
            rx_done_tick <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        s     <= '0;
                        state <= START;
                    end
                end
                START: begin
                    if (s_tick) begin
                        if (s == S_MID) begin
                            // A line that has gone high again by mid start
                            // bit was a glitch, not a frame.
                            if (!rx_s) begin
                                s     <= '0;
                                n     <= '0;
                                state <= DATA;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (s_tick) begin
                        if (s == S_LAST) begin
                            b <= {rx_s, b[DBIT-1:1]};
                            s <= '0;
                            if (n == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                                state <= PARITY;
`else
                                state <= STOP;
`endif
                            end else begin
                                n <= n + 1'b1;
                            end
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (s_tick) begin
                        if (s == S_LAST) begin
                            par_pend <= (^b) ^ rx_s ^ (PARITY_ODD != 0);
                            s        <= '0;
                            state    <= STOP;
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
`endif
                STOP: begin
                    if (s_tick) begin
                        if (s == S_STOP) begin
                            dout         <= b;
                            rx_done_tick <= 1'b1;
                            frame_err    <= ~rx_s;
`ifdef UART_RX_PARITY_EN
                            par_err_reg  <= par_pend;
`endif
                            state        <= IDLE;
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_deser.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_deser
// Directed bench for uart_rx_deser: s_tick every 4 clk, frames driven bit by
// bit in tick units, completions recorded by a negedge monitor.
// Build with UART_RX_PARITY_EN defined to also exercise the parity bit.
// ---------------------------------------------------------------------------
module tb_uart_rx_deser;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx = 1'b1;
    logic       s_tick = 1'b0;
    logic [7:0] dout;
    logic       rx_done_tick;
    logic       frame_err;
    logic       parity_err;

    int passed = 0;
    int total  = 0;

    int         pulse_cnt = 0;
    logic [7:0] hist_d [0:63];
    logic       hist_f [0:63];
    logic       hist_p [0:63];
    int         base;

    uart_rx_deser #(
        .DBIT       (8),
        .SB_TICK    (16),
        .PARITY_ODD (0)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx           (rx),
        .s_tick       (s_tick),
        .dout         (dout),
        .rx_done_tick (rx_done_tick),
        .frame_err    (frame_err),
        .parity_err   (parity_err)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    // Baud tick: one clk wide, every 4th clk, changed on the falling edge.
    initial begin
        int k;
        k = 0;
        forever begin
            @(negedge clk);
            k = k + 1;
            s_tick = ((k % 4) == 0);
        end
    end

    // Record every completion pulse, sampled mid-cycle.
    always @(negedge clk) begin
        if (rx_done_tick === 1'b1) begin
            if (pulse_cnt < 64) begin
                hist_d[pulse_cnt] = dout;
                hist_f[pulse_cnt] = frame_err;
                hist_p[pulse_cnt] = parity_err;
            end
            pulse_cnt = pulse_cnt + 1;
        end
    end

    // Hard stop if something wedges.
    initial begin
        #3_000_000;
        $display("[TB] FAIL timeout: simulation did not finish in time");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        total = total + 1;
        assert (observed === expected) passed = passed + 1;
        else $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    endtask

    task automatic waitTicks(input int cnt);
        for (int i = 0; i < cnt; i++) begin
            @(posedge clk);
            while (s_tick !== 1'b1) @(posedge clk);
        end
    endtask

    task automatic driveBit(input logic v, input int ticks);
        @(negedge clk);
        rx = v;
        waitTicks(ticks);
    endtask

    // Full frame: start, LSB-first data, optional parity, stop of given
    // level and length; the line is left high afterwards.
    task automatic applyStimulus(input logic [7:0] data, input logic par,
                                 input logic stop_v, input int stop_ticks);
        driveBit(1'b0, 16);
        for (int i = 0; i < 8; i++) driveBit(data[i], 16);
`ifdef UART_RX_PARITY_EN
        driveBit(par, 16);
`else
        if (par === 1'bx) $display("[TB] note: parity bit unused");
`endif
        driveBit(stop_v, stop_ticks);
        @(negedge clk);
        rx = 1'b1;
    endtask

    initial begin
        $display("[TB] start");
        // Reset state.
        repeat (4) @(negedge clk);
        checkOutput("reset_dout", int'(dout), 0);
        checkOutput("reset_done", int'(rx_done_tick), 0);
        checkOutput("reset_ferr", int'(frame_err), 0);
        checkOutput("reset_perr", int'(parity_err), 0);
        reset = 1'b1;
        waitTicks(20);

        // Plain good frame.
        base = pulse_cnt;
        applyStimulus(8'hA5, ^8'hA5, 1'b1, 16);
        checkOutput("a5_pulses", pulse_cnt - base, 1);
        checkOutput("a5_dout", int'(hist_d[base]), 8'hA5);
        checkOutput("a5_ferr", int'(hist_f[base]), 0);
        checkOutput("a5_perr", int'(hist_p[base]), 0);

        // False start: low for 3 ticks only.
        base = pulse_cnt;
        driveBit(1'b0, 3);
        driveBit(1'b1, 30);
        checkOutput("false_start_pulses", pulse_cnt - base, 0);
        applyStimulus(8'h3C, ^8'h3C, 1'b1, 16);
        checkOutput("3c_pulses", pulse_cnt - base, 1);
        checkOutput("3c_dout", int'(hist_d[base]), 8'h3C);

        // Framing error: stop bit low. It is shortened so the line is high
        // again before the re-entered START reaches its mid-bit check.
        base = pulse_cnt;
        applyStimulus(8'h81, ^8'h81, 1'b0, 12);
        waitTicks(24);
        checkOutput("81_pulses", pulse_cnt - base, 1);
        checkOutput("81_dout", int'(hist_d[base]), 8'h81);
        checkOutput("81_ferr", int'(hist_f[base]), 1);
        checkOutput("81_ferr_held", int'(frame_err), 1);
        checkOutput("81_dout_held", int'(dout), 8'h81);
        applyStimulus(8'h55, ^8'h55, 1'b1, 16);
        checkOutput("55_pulses", pulse_cnt - base, 2);
        checkOutput("55_dout", int'(hist_d[base + 1]), 8'h55);
        checkOutput("55_ferr", int'(hist_f[base + 1]), 0);

        // Back-to-back frames without idle gap.
        waitTicks(8);
        base = pulse_cnt;
        applyStimulus(8'h00, ^8'h00, 1'b1, 16);
        applyStimulus(8'hFF, ^8'hFF, 1'b1, 16);
        applyStimulus(8'h5A, ^8'h5A, 1'b1, 16);
        checkOutput("b2b_pulses", pulse_cnt - base, 3);
        checkOutput("b2b_dout0", int'(hist_d[base]), 8'h00);
        checkOutput("b2b_dout1", int'(hist_d[base + 1]), 8'hFF);
        checkOutput("b2b_dout2", int'(hist_d[base + 2]), 8'h5A);
        checkOutput("b2b_ferr1", int'(hist_f[base + 1]), 0);

        // Reset mid-frame after 4 data bits of 0xC3.
        waitTicks(8);
        base = pulse_cnt;
        driveBit(1'b0, 16);
        driveBit(1'b1, 16);
        driveBit(1'b1, 16);
        driveBit(1'b0, 16);
        driveBit(1'b0, 16);
        @(negedge clk);
        rx = 1'b1;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        checkOutput("rst_mid_dout", int'(dout), 0);
        waitTicks(20);
        applyStimulus(8'h12, ^8'h12, 1'b1, 16);
        waitTicks(4);
        checkOutput("rst_mid_pulses", pulse_cnt - base, 1);
        checkOutput("12_dout", int'(hist_d[base]), 8'h12);
        checkOutput("12_ferr", int'(hist_f[base]), 0);

`ifdef UART_RX_PARITY_EN
        // Even parity: 0x07 has three ones, so a parity bit of 1 is correct.
        waitTicks(8);
        base = pulse_cnt;
        applyStimulus(8'h07, 1'b1, 1'b1, 16);
        applyStimulus(8'h07, 1'b0, 1'b1, 16);
        checkOutput("par_pulses", pulse_cnt - base, 2);
        checkOutput("par_good_dout", int'(hist_d[base]), 8'h07);
        checkOutput("par_good_perr", int'(hist_p[base]), 0);
        checkOutput("par_bad_dout", int'(hist_d[base + 1]), 8'h07);
        checkOutput("par_bad_perr", int'(hist_p[base + 1]), 1);
        checkOutput("par_bad_ferr", int'(hist_f[base + 1]), 0);
`endif

        waitTicks(8);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/uart_rx_deser.md
# uart_rx_deser

UART receive deserializer: oversamples the asynchronous serial line on a 16x baud tick, validates start and stop bits, and assembles LSB-first data words. Sits directly upstream of the receive FIFO. `rx_done_tick` drives the FIFO `wr`, and `dout` drives `w_data`. Flags framing errors and, optionally, parity errors alongside each word.

## Interface
- `DBIT`, 8: data bits per frame.
- `SB_TICK`, 16: s_tick count for the stop period (16 = 1 stop bit, 24 = 1.5, 32 = 2).
- `PARITY_ODD`, 0: parity sense when parity is compiled in (0 = even, 1 = odd).
- `clk` input 1: single clock; all state changes on its rising edge.
- `reset` input 1: synchronous, active-low; sampled on the rising edge of `clk`.
- `rx` input 1: asynchronous serial line; idle level 1.
- `s_tick` input 1: one-`clk` enable pulse at 16x the baud rate, from the baud generator.
- `dout` output DBIT: last completed word; updated only on frame completion.
- `rx_done_tick` output 1: one-cycle pulse when a frame completes; connects to FIFO `wr`.
- `frame_err` output 1: stop bit sampled low; valid while `rx_done_tick` is high.
- `parity_err` output 1: parity mismatch; valid while `rx_done_tick` is high.

## Operation
- `rx` passes through a 2-flop synchronizer; the reset value of both flops is 1. All decisions below use the synchronized value `rx_s`.
- Counters:
  - `s`: 4-bit tick counter, wraps modulo 16; for the stop state it is widened to $clog2(SB_TICK).
  - `n`: $clog2(DBIT)-bit bit counter.
- Counters advance only on cycles with `s_tick` = 1. Between ticks, FSM state and counters hold.
- FSM states and transitions:
  - IDLE: on `rx_s` = 0, clear `s` and go to START. No `s_tick` is needed to leave IDLE.
  - START: when `s` = 7 on a tick (mid start bit):
    - `rx_s` = 0: clear `s` and `n`, go to DATA.
    - `rx_s` = 1: false start; return to IDLE with no pulse and no flags.
  - DATA: when `s` = 15 on a tick, shift `rx_s` into the MSB of the shift register (LSB-first frame) and clear `s`.
    - When `n` = DBIT-1 at that point, go to PARITY (macro defined) or STOP.
    - Otherwise increment `n`.
  - PARITY: when `s` = 15 on a tick, compute XOR of the shifted bits, `rx_s` and `PARITY_ODD`. A nonzero result latches a pending parity error. Clear `s` and go to STOP.
  - STOP: when `s` = SB_TICK-1 on a tick, sample `rx_s`, capture completion and return to IDLE.
- Completion, registered one cycle after the final stop tick:
  - `dout` takes the shift register.
  - `rx_done_tick` = 1 for exactly one cycle.
  - `frame_err` = ~`rx_s` at the stop sample.
  - `parity_err` takes the pending flag.
- Framing-error and parity-error frames still pulse `rx_done_tick` and are written to the FIFO. Consumers qualify the word with the flags.
- `frame_err` and `parity_err` hold their values until the next completion.
- Reset mid-frame: the partial word is discarded, with no pulse. After reset the FSM is in IDLE and a low `rx` starts a new frame.
- Line stuck low: after a framing error, IDLE sees `rx_s` = 0 and re-enters START. A continuously low line therefore produces repeated frames of `dout` = 0 with `frame_err` = 1.

## Timing
- Reset values: `dout` = 0, `rx_done_tick` = 0, `frame_err` = 0, `parity_err` = 0, FSM = IDLE, `s` = `n` = 0, synchronizer flops = 1.
- Input latency: 2 `clk` from `rx` to `rx_s`.
- Output latency: `rx_done_tick` rises 1 `clk` after the `clk` carrying the final stop tick.
- Frame length: 8 + 16·DBIT (+16 with parity) + SB_TICK ticks from the first low `rx_s` tick, ±1 tick of detection jitter.
- Back-to-back frames: the next start bit may begin on the tick after the stop sample; no dead time is required.
- The FIFO must accept `wr` on any cycle. The block has no back-pressure, so a full FIFO drops the word.

## Configuration
- `UART_RX_PARITY_EN`:
  - Defined: the PARITY state is present, one parity bit follows the data bits, and `parity_err` is computed per `PARITY_ODD`.
  - Undefined: no PARITY state, DATA goes directly to STOP, and `parity_err` is tied to 0.
- Port list is identical in both builds.

## Structure
- Shared package `uart_pkg`:
  - `rx_state_t` enum (IDLE, START, DATA, PARITY, STOP).
  - `OVERSAMPLE` = 16 and `START_MID` = 7 constants.
  - Default DBIT and SB_TICK values.
- One sub-module, `rx_sync`: 2-flop synchronizer with reset value 1. The rest is one FSM with registered outputs.

## Test plan
- s_tick every 4 clk; frame 0xA5 with stop = 1 → one `rx_done_tick`, `dout` = 0xA5, `frame_err` = 0.
- `rx` low for 3 ticks, then high → no `rx_done_tick`; FSM back in IDLE; a following 0x3C frame → `dout` = 0x3C.
- Frame 0x81 with stop bit driven 0 → `rx_done_tick` = 1, `dout` = 0x81, `frame_err` = 1. Next good 0x55 frame → `frame_err` = 0.
- Frames 0x00, 0xFF, 0x5A back-to-back, no idle gap → three pulses with `dout` 0x00, 0xFF, 0x5A in order.
- `reset` = 0 for 1 clk after 4 data bits of 0xC3, then a full 0x12 frame → only one pulse, `dout` = 0x12.
- With `UART_RX_PARITY_EN`, `PARITY_ODD` = 0: 0x07 with parity 1 → `parity_err` = 0; 0x07 with parity 0 → `parity_err` = 1, and `dout` = 0x07 in both cases.
